// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: default operand width,
// opcode encodings and the controller FSM state encoding.
package alu_pkg;

  localparam int unsigned WordSize = 32;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_DIV = 5'd2;
  localparam logic [4:0] OP_AND = 5'd3;
  localparam logic [4:0] OP_OR  = 5'd4;
  localparam logic [4:0] OP_XOR = 5'd5;
  localparam logic [4:0] OP_MUL = 5'd6;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StExec,
    StCapture,
    StMul,
    StResp
  } state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request / ALU / response signal bundle for alu_issue_ctrl.
//   master : requester + ALU side (drives requests, ALU results, rsp_ready)
//   slave  : the controller (drives req_ready, ALU operands/select, response)
interface alu_issue_ctrl_if
  import alu_pkg::*;
#(
  parameter int unsigned word_size = WordSize
) ();

  logic                 req_valid;
  logic                 req_ready;
  logic [4:0]           req_op;
  logic [word_size-1:0] req_a;
  logic [word_size-1:0] req_b;
  logic [word_size-1:0] alu_A;
  logic [word_size-1:0] alu_B;
  logic [4:0]           alu_sel;
  logic [word_size-1:0] alu_low;
  logic [word_size-1:0] alu_high;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [word_size-1:0] rsp_low;
  logic [word_size-1:0] rsp_high;
  logic                 rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, alu_low, alu_high, rsp_ready,
    input  req_ready, alu_A, alu_B, alu_sel, rsp_valid, rsp_low, rsp_high, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_low, alu_high, rsp_ready,
    output req_ready, alu_A, alu_B, alu_sel, rsp_valid, rsp_low, rsp_high, rsp_err
  );

endinterface

// File: rtl/shift_add_mul.sv
// Unsigned word_size x word_size shift-add multiplier, one partial product per
// cycle. Only instantiated when ALU_ISSUE_MUL_EN is defined.
//   clk, clr_n  : clock, async active-low reset
//   start_i     : load operands (the first step is done on the load edge)
//   a_i, b_i    : multiplicand, multiplier
//   busy_o      : steps still outstanding
//   done_o      : one-cycle pulse, product_o is complete
//   product_o   : 2*word_size-bit product
module shift_add_mul
  import alu_pkg::*;
#(
  parameter int unsigned word_size = WordSize
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   start_i,
  input  logic [word_size-1:0]   a_i,
  input  logic [word_size-1:0]   b_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [2*word_size-1:0] product_o
);

  localparam int unsigned CntW = $clog2(word_size + 1);

  logic [word_size-1:0]   mcand_q, mcand_d;
  logic [2*word_size-1:0] prod_q, prod_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   done_q, done_d;

  // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
  function automatic logic [2*word_size-1:0] mul_step(input logic [2*word_size-1:0] p,
                                                      input logic [word_size-1:0]   m);
    logic [word_size:0] sum;
    sum = {1'b0, p[2*word_size-1:word_size]} + (p[0] ? {1'b0, m} : '0);
    return {sum, p[word_size-1:1]};
  endfunction

  always_comb begin
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (start_i) begin
      mcand_d = a_i;
      prod_d  = mul_step({{word_size{1'b0}}, b_i}, a_i);
      cnt_d   = CntW'(word_size - 1);
      done_d  = (word_size == 1);
    end else if (cnt_q != '0) begin
      prod_d = mul_step(prod_q, mcand_q);
      cnt_d  = cnt_q - CntW'(1);
      done_d = (cnt_q == CntW'(1));
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy_o    = (cnt_q != '0);
  assign done_o    = done_q;
  assign product_o = prod_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for a registered external ALU. Accepts one operation at a
// time, drives the ALU for DRIVE..CAPTURE, captures its result and holds the
// response until handshaked. Illegal ops and divide-by-zero answer directly.
// Optional multiply path: define ALU_ISSUE_MUL_EN (op 6 via shift_add_mul),
// otherwise op 6 is illegal.
//   clk, clr_n : clock, async active-low reset
//   bus_io     : alu_issue_ctrl_if.slave (request, ALU drive/result, response)
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned word_size = WordSize
) (
  input logic             clk,
  input logic             clr_n,
  alu_issue_ctrl_if.slave bus_io
);

  state_e               state_q, state_d;
  logic [4:0]           op_q, op_d;
  logic [word_size-1:0] a_q, a_d, b_q, b_d;
  logic [word_size-1:0] rsp_low_q, rsp_low_d, rsp_high_q, rsp_high_d;
  logic                 rsp_err_q, rsp_err_d;

  logic                   accept, op_legal, div_zero;
  logic                   mul_busy, mul_done;
  logic [2*word_size-1:0] mul_product;

  assign accept   = bus_io.req_valid && bus_io.req_ready;
  assign div_zero = (bus_io.req_op == OP_DIV) && (bus_io.req_b == '0);

`ifdef ALU_ISSUE_MUL_EN
  assign op_legal = (bus_io.req_op <= OP_MUL);

  shift_add_mul #(
    .word_size(word_size)
  ) u_mul (
    .clk      (clk),
    .clr_n    (clr_n),
    .start_i  (accept && (bus_io.req_op == OP_MUL)),
    .a_i      (bus_io.req_a),
    .b_i      (bus_io.req_b),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .product_o(mul_product)
  );
`else
  assign op_legal    = (bus_io.req_op <= OP_XOR);
  assign mul_busy    = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  // State register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (!op_legal || div_zero)        state_d = StResp;
          else if (bus_io.req_op == OP_MUL) state_d = StMul;
          else                              state_d = StDrive;
        end
      end
      StDrive:   state_d = StExec;
      StExec:    state_d = StCapture;
      StCapture: state_d = StResp;
      StMul:     if (mul_done) state_d = StResp;
      StResp:    if (bus_io.rsp_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Operand latch and response datapath
  always_comb begin
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_low_d  = rsp_low_q;
    rsp_high_d = rsp_high_q;
    rsp_err_d  = rsp_err_q;
    if (accept) begin
      op_d       = bus_io.req_op;
      a_d        = bus_io.req_a;
      b_d        = bus_io.req_b;
      rsp_err_d  = !op_legal || div_zero;
      rsp_low_d  = div_zero ? '1 : '0;
      rsp_high_d = '0;
    end else if (state_q == StCapture) begin
      rsp_low_d  = bus_io.alu_low;
      rsp_high_d = bus_io.alu_high;
    end else if ((state_q == StMul) && mul_done) begin
      {rsp_high_d, rsp_low_d} = mul_product;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_low_q  <= '0;
      rsp_high_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_low_q  <= rsp_low_d;
      rsp_high_q <= rsp_high_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Outputs. req_ready looks at clr_n directly so it stays low during reset.
  always_comb begin
    bus_io.req_ready = 1'b0;
    bus_io.rsp_valid = 1'b0;
    bus_io.alu_A     = '0;
    bus_io.alu_B     = '0;
    bus_io.alu_sel   = '0;
    case (state_q)
      StIdle: bus_io.req_ready = clr_n && !mul_busy;
      StDrive, StExec, StCapture: begin
        bus_io.alu_A   = a_q;
        bus_io.alu_B   = b_q;
        bus_io.alu_sel = op_q;
      end
      StResp:  bus_io.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus_io.rsp_low  = rsp_low_q;
  assign bus_io.rsp_high = rsp_high_q;
  assign bus_io.rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a registered ALU model.
// Cycle numbering: the cycle in which the request is accepted is cycle 0.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic clk;
  logic clr_n;
  int   n_checks = 0;
  int   n_errors = 0;

  alu_issue_ctrl_if #(.word_size(32)) bus ();

  alu_issue_ctrl #(
    .word_size(32)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: result registered one cycle after its inputs.
  logic [63:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (bus.alu_sel)
      5'd0: alu_res = {32'b0, bus.alu_A + bus.alu_B};
      5'd1: alu_res = {32'b0, bus.alu_A - bus.alu_B};
      5'd2: alu_res = (bus.alu_B != 0) ? {32'b0, bus.alu_A / bus.alu_B} : 64'b0;
      5'd3: alu_res = {32'b0, bus.alu_A & bus.alu_B};
      5'd4: alu_res = {32'b0, bus.alu_A | bus.alu_B};
      5'd5: alu_res = {32'b0, bus.alu_A ^ bus.alu_B};
      5'd6: alu_res = {32'b0, bus.alu_A} * {32'b0, bus.alu_B};
      default: alu_res = '0;
    endcase
  end
  always @(posedge clk) begin
    bus.alu_low  <= alu_res[31:0];
    bus.alu_high <= alu_res[63:32];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait (bounded) for acceptance; returns in cycle 1.
  task automatic do_req(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      step();
      n++;
    end
    check_eq("req_ready_at_accept", {63'b0, bus.req_ready}, 64'd1);
    step();
    bus.req_valid = 1'b0;
  endtask

  // Called in cycle 1; returns the cycle (relative to accept) of rsp_valid.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!bus.rsp_valid && lat < 60) begin
      step();
      lat++;
    end
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  int lat;

  initial begin
    clr_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    #3;
    check_eq("rst_req_ready", {63'b0, bus.req_ready}, 64'd0);
    check_eq("rst_rsp_valid", {63'b0, bus.rsp_valid}, 64'd0);
    check_eq("rst_rsp_low", {32'b0, bus.rsp_low}, 64'd0);
    check_eq("rst_alu_A", {32'b0, bus.alu_A}, 64'd0);
    step();
    step();
    clr_n = 1'b1;
    step();
    check_eq("post_rst_req_ready", {63'b0, bus.req_ready}, 64'd1);

    // Add 5 + 7
    do_req(OP_ADD, 32'd5, 32'd7);
    check_eq("add_drive_alu_A", {32'b0, bus.alu_A}, 64'd5);
    check_eq("add_drive_alu_B", {32'b0, bus.alu_B}, 64'd7);
    check_eq("add_drive_alu_sel", {59'b0, bus.alu_sel}, 64'd0);
    check_eq("add_drive_req_ready", {63'b0, bus.req_ready}, 64'd0);
    step();
    step();
    check_eq("add_capture_alu_A", {32'b0, bus.alu_A}, 64'd5);
    step();
    lat = 4;
    if (!bus.rsp_valid) wait_rsp(lat);
    check_eq("add_latency", 64'(lat), 64'd4);
    check_eq("add_rsp_low", {32'b0, bus.rsp_low}, 64'd12);
    check_eq("add_rsp_high", {32'b0, bus.rsp_high}, 64'd0);
    check_eq("add_rsp_err", {63'b0, bus.rsp_err}, 64'd0);
    check_eq("add_resp_alu_A", {32'b0, bus.alu_A}, 64'd0);
    handshake();
    check_eq("add_idle_after_hs", {63'b0, bus.req_ready}, 64'd1);

    // Divide by zero
    do_req(OP_DIV, 32'd100, 32'd0);
    check_eq("div0_alu_sel", {59'b0, bus.alu_sel}, 64'd0);
    check_eq("div0_alu_A", {32'b0, bus.alu_A}, 64'd0);
    wait_rsp(lat);
    check_eq("div0_latency", 64'(lat), 64'd1);
    check_eq("div0_rsp_err", {63'b0, bus.rsp_err}, 64'd1);
    check_eq("div0_rsp_low", {32'b0, bus.rsp_low}, 64'hFFFF_FFFF);
    check_eq("div0_rsp_high", {32'b0, bus.rsp_high}, 64'd0);
    handshake();

    // Legal divide 100 / 7
    do_req(OP_DIV, 32'd100, 32'd7);
    wait_rsp(lat);
    check_eq("div_latency", 64'(lat), 64'd4);
    check_eq("div_rsp_low", {32'b0, bus.rsp_low}, 64'd14);
    check_eq("div_rsp_err", {63'b0, bus.rsp_err}, 64'd0);
    handshake();

    // Illegal op 9
    do_req(5'd9, 32'd3, 32'd4);
    check_eq("ill_alu_A", {32'b0, bus.alu_A}, 64'd0);
    wait_rsp(lat);
    check_eq("ill_latency", 64'(lat), 64'd1);
    check_eq("ill_rsp_err", {63'b0, bus.rsp_err}, 64'd1);
    check_eq("ill_rsp_low", {32'b0, bus.rsp_low}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("ill_req_ready_held", {63'b0, bus.req_ready}, 64'd0);
    end
    handshake();
    check_eq("ill_idle_after_hs", {63'b0, bus.req_ready}, 64'd1);

    // XOR with backpressure
    do_req(OP_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    wait_rsp(lat);
    check_eq("xor_latency", 64'(lat), 64'd4);
    for (int i = 0; i < 6; i++) begin
      check_eq("xor_rsp_low_stable", {32'b0, bus.rsp_low}, 64'hFF00_FF00);
      check_eq("xor_rsp_valid_held", {63'b0, bus.rsp_valid}, 64'd1);
      check_eq("xor_req_ready_low", {63'b0, bus.req_ready}, 64'd0);
      step();
    end
    handshake();
    check_eq("xor_idle_req_ready", {63'b0, bus.req_ready}, 64'd1);
    check_eq("xor_idle_rsp_valid", {63'b0, bus.rsp_valid}, 64'd0);

    // Multiply 0xFFFFFFFF * 2
    do_req(OP_MUL, 32'hFFFF_FFFF, 32'd2);
    wait_rsp(lat);
`ifdef ALU_ISSUE_MUL_EN
    check_eq("mul_latency", 64'(lat), 64'd33);
    check_eq("mul_rsp_high", {32'b0, bus.rsp_high}, 64'd1);
    check_eq("mul_rsp_low", {32'b0, bus.rsp_low}, 64'hFFFF_FFFE);
    check_eq("mul_rsp_err", {63'b0, bus.rsp_err}, 64'd0);
`else
    check_eq("mul_off_latency", 64'(lat), 64'd1);
    check_eq("mul_off_rsp_err", {63'b0, bus.rsp_err}, 64'd1);
    check_eq("mul_off_rsp_low", {32'b0, bus.rsp_low}, 64'd0);
`endif
    handshake();

    // Reset during EXEC of a subtract
    do_req(OP_SUB, 32'd50, 32'd8);
    step();
    check_eq("sub_exec_alu_B", {32'b0, bus.alu_B}, 64'd8);
    clr_n = 1'b0;
    #2;
    check_eq("abort_req_ready", {63'b0, bus.req_ready}, 64'd0);
    check_eq("abort_rsp_valid", {63'b0, bus.rsp_valid}, 64'd0);
    check_eq("abort_rsp_err", {63'b0, bus.rsp_err}, 64'd0);
    check_eq("abort_alu_A", {32'b0, bus.alu_A}, 64'd0);
    check_eq("abort_alu_B", {32'b0, bus.alu_B}, 64'd0);
    check_eq("abort_alu_sel", {59'b0, bus.alu_sel}, 64'd0);
    check_eq("abort_rsp_low", {32'b0, bus.rsp_low}, 64'd0);
    check_eq("abort_rsp_high", {32'b0, bus.rsp_high}, 64'd0);
    step();
    clr_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("abort_no_rsp", {63'b0, bus.rsp_valid}, 64'd0);
    end
    check_eq("abort_req_ready_back", {63'b0, bus.req_ready}, 64'd1);
    do_req(OP_SUB, 32'd50, 32'd8);
    wait_rsp(lat);
    check_eq("sub_latency", 64'(lat), 64'd4);
    check_eq("sub_rsp_low", {32'b0, bus.rsp_low}, 64'd42);
    check_eq("sub_rsp_err", {63'b0, bus.rsp_err}, 64'd0);
    handshake();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter: word_size, default 32, operand/result width; all 32-bit ports below scale with it.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 clr_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  operation request present.
REQ-005 req_ready  out  1  block can accept a request.
REQ-006 req_op  in  5  opcode: 0 add, 1 sub, 2 div, 3 and, 4 or, 5 xor, 6 mul, others illegal.
REQ-007 req_a / req_b  in  32 each  operands.
REQ-008 alu_A / alu_B  out  32 each  operands driven to the ALU.
REQ-009 alu_sel  out  5  ALU select.
REQ-010 alu_low / alu_high  in  32 each  ALU results; the ALU registers them, so they are valid one cycle after its inputs are set.
REQ-011 rsp_valid  out  1  result available; rsp_ready  in  1  consumer accepts.
REQ-012 rsp_low / rsp_high  out  32 each  result words; rsp_err  out  1  operation rejected.

Function
REQ-013 One outstanding operation at a time; req_ready SHALL be 1 only in IDLE.
REQ-014 A request SHALL be accepted on a cycle with req_valid && req_ready; req_op, req_a and req_b are latched on that edge.
REQ-015 FSM states: IDLE, DRIVE, EXEC, CAPTURE, MUL, RESP.
REQ-016 Transitions from IDLE on accept:
- op 0-5 with a legal divisor -> DRIVE
- op 6 -> MUL
- illegal op, or op 2 with req_b==0 -> RESP
REQ-017 DRIVE -> EXEC -> CAPTURE -> RESP, one cycle each.
REQ-018 ALU drive: alu_A, alu_B and alu_sel SHALL hold the latched values from DRIVE through CAPTURE. In all other states they SHALL be 0.
REQ-019 In CAPTURE, alu_low and alu_high SHALL be registered into rsp_low and rsp_high.
REQ-020 Latency: rsp_valid SHALL rise exactly 4 cycles after the accept edge for ops 0-5.
REQ-021 In RESP, rsp_valid=1 and rsp_low, rsp_high and rsp_err SHALL stay stable until rsp_valid && rsp_ready, then return to IDLE.
REQ-022 The next request can be accepted no earlier than the cycle after the response handshake.
REQ-023 Illegal op: rsp_err=1, rsp_low=0, rsp_high=0; rsp_valid 1 cycle after accept; the ALU is not driven.
REQ-024 Divide by zero (op 2, b==0): rsp_err=1, rsp_low=all ones, rsp_high=0; rsp_valid 1 cycle after accept; the ALU is not driven.
REQ-025 rsp_err SHALL be 0 for every successful operation.

Reset
REQ-026 clr_n low SHALL immediately force:
- state to IDLE
- req_ready=0 while clr_n is low, 1 on the first cycle after release
- rsp_valid=0, rsp_err=0
- rsp_low, rsp_high, alu_A, alu_B and alu_sel to 0
REQ-027 Reset during any non-IDLE state SHALL abort the operation with no response.

Configuration
REQ-028 Macro ALU_ISSUE_MUL_EN controls the multiply path.
- Defined: op 6 is an unsigned word_size x word_size shift-add multiply, one bit per cycle, word_size cycles in MUL. rsp_high holds the upper and rsp_low the lower product word. rsp_valid rises word_size+1 cycles after accept.
- Undefined: op 6 is treated as an illegal op (REQ-023), and no multiply logic is synthesised.

Structure
REQ-029 Shared package alu_pkg SHALL hold:
- opcode constants (OP_ADD .. OP_MUL)
- the FSM state encoding
- the default word_size
REQ-030 The multiply datapath SHALL be a sub-module shift_add_mul (start, busy, done, 64-bit product), instantiated only under ALU_ISSUE_MUL_EN.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- op 0, a=5, b=7 -> alu_sel=0 during DRIVE..CAPTURE; rsp_low=12, rsp_high=0, rsp_err=0, rsp_valid at accept+4.
- op 2, a=100, b=0 -> rsp_err=1, rsp_low=32'hFFFFFFFF at accept+1; alu_sel and alu_A stay 0.
- op 9 -> rsp_err=1, rsp_low=0; req_ready=0 until the response handshake.
- op 5, a=32'hF0F0F0F0, b=32'h0FF00FF0, rsp_ready held 0 for 6 cycles -> rsp_low=32'hFF00FF00 held stable; req_ready=0 throughout; IDLE the cycle after rsp_ready=1.
- ALU_ISSUE_MUL_EN defined, op 6, a=32'hFFFFFFFF, b=2 -> rsp_high=1, rsp_low=32'hFFFFFFFE at accept+33. Undefined: same stimulus -> rsp_err=1.
- clr_n pulsed low in EXEC of an op 1 -> no rsp_valid; all outputs 0; new request accepted after release.
